// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, register-file and operand handshake signals of the operand fetch sequencer.
interface operand_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int TAG_WIDTH  = 8
);
  logic                  inst_valid;
  logic                  inst_ready;
  logic [ADDR_WIDTH-1:0] inst_src1;
  logic [ADDR_WIDTH-1:0] inst_src2;
  logic [TAG_WIDTH-1:0]  inst_tag;
  logic [ADDR_WIDTH-1:0] readReg1;
  logic [ADDR_WIDTH-1:0] readReg2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic [ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] writeFile;
  logic                  regWrite;
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic [TAG_WIDTH-1:0]  op_tag;
  modport master (
    output inst_valid, inst_src1, inst_src2, inst_tag, readData1, readData2,
           writeReg, writeFile, regWrite, op_ready,
    input  inst_ready, readReg1, readReg2, op_valid, opA, opB, op_tag
  );
  modport slave (
    input  inst_valid, inst_src1, inst_src2, inst_tag, readData1, readData2,
           writeReg, writeFile, regWrite, op_ready,
    output inst_ready, readReg1, readReg2, op_valid, opA, opB, op_tag
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: drives register-file read ports, hides its one-cycle read latency and forwards writebacks into the delivered operands.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int TAG_WIDTH  = 8
) (
  input logic clock,
  input logic reset_n,
  operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, VALID} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [ADDR_WIDTH-1:0] read_reg1_q, read_reg1_d, read_reg2_q, read_reg2_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d, op_tag_q, op_tag_d;
  logic                  fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [DATA_WIDTH-1:0] fwd1_data_q, fwd1_data_d, fwd2_data_q, fwd2_data_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic                  inst_ready_q, inst_ready_d, op_valid_q, op_valid_d;
  logic                  hit1, hit2;
  always_comb begin
    hit1        = bus.regWrite && bus.writeReg == src1_q;
    hit2        = bus.regWrite && bus.writeReg == src2_q;
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    tag_d       = tag_q;
    read_reg1_d = read_reg1_q;
    read_reg2_d = read_reg2_q;
    op_tag_d    = op_tag_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    fwd1_data_d = fwd1_data_q;
    fwd2_data_d = fwd2_data_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    inst_ready_d = inst_ready_q;
    op_valid_d  = op_valid_q;
    case (state_q)
      IDLE: if (bus.inst_valid) begin
        src1_d       = bus.inst_src1;
        src2_d       = bus.inst_src2;
        tag_d        = bus.inst_tag;
        read_reg1_d  = bus.inst_src1;
        read_reg2_d  = bus.inst_src2;
        inst_ready_d = 1'b0;
        state_d      = ISSUE;
      end
      // the file reads before it writes, so an ISSUE-cycle write must be remembered here
      ISSUE: begin
        fwd1_d      = hit1;
        fwd2_d      = hit2;
        fwd1_data_d = bus.writeFile;
        fwd2_data_d = bus.writeFile;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        op_a_d     = hit1 ? bus.writeFile : fwd1_q ? fwd1_data_q : bus.readData1;
        op_b_d     = hit2 ? bus.writeFile : fwd2_q ? fwd2_data_q : bus.readData2;
        fwd1_d     = 1'b0;
        fwd2_d     = 1'b0;
        op_tag_d   = tag_q;
        op_valid_d = 1'b1;
        state_d    = VALID;
      end
      VALID: begin
        op_a_d = hit1 ? bus.writeFile : op_a_q;
        op_b_d = hit2 ? bus.writeFile : op_b_q;
        if (bus.op_ready) begin
          op_valid_d   = 1'b0;
          inst_ready_d = 1'b1;
          state_d      = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      src1_q       <= '0;
      src2_q       <= '0;
      tag_q        <= '0;
      read_reg1_q  <= '0;
      read_reg2_q  <= '0;
      op_tag_q     <= '0;
      fwd1_q       <= 1'b0;
      fwd2_q       <= 1'b0;
      fwd1_data_q  <= '0;
      fwd2_data_q  <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      inst_ready_q <= 1'b1;
      op_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      tag_q        <= tag_d;
      read_reg1_q  <= read_reg1_d;
      read_reg2_q  <= read_reg2_d;
      op_tag_q     <= op_tag_d;
      fwd1_q       <= fwd1_d;
      fwd2_q       <= fwd2_d;
      fwd1_data_q  <= fwd1_data_d;
      fwd2_data_q  <= fwd2_data_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      inst_ready_q <= inst_ready_d;
      op_valid_q   <= op_valid_d;
    end
  end
  assign bus.inst_ready = inst_ready_q;
  assign bus.readReg1   = read_reg1_q;
  assign bus.readReg2   = read_reg2_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.opA        = op_a_q;
  assign bus.opB        = op_b_q;
  assign bus.op_tag     = op_tag_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized fetches checked against a behavioural register-file model.
module tb_operand_fetch;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int fails = 0;
  bit rnd = 1'b0;
  logic [2:0] cur1 = '0, cur2 = '0;
  logic [15:0] rf [8] = '{16'd0, 16'd0, 16'd256, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  logic [15:0] rd1 = '0, rd2 = '0;
  operand_fetch_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .TAG_WIDTH(8)) bus ();
  operand_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .TAG_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    rd1 <= rf[bus.readReg1];
    rd2 <= rf[bus.readReg2];
    if (bus.regWrite) rf[bus.writeReg] <= bus.writeFile;
  end
  assign bus.readData1 = rd1;
  assign bus.readData2 = rd2;
  function automatic logic [19:0] wv(input logic en, input logic [2:0] r, input logic [15:0] d);
    return {en, r, d};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [19:0] w);
    if (rnd) begin
      bus.regWrite  = 1'($urandom_range(0, 1));
      bus.writeReg  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : ($urandom_range(0, 1) != 0 ? cur1 : cur2);
      bus.writeFile = 16'($urandom);
    end else {bus.regWrite, bus.writeReg, bus.writeFile} = w;
  endtask
  task automatic busy_inputs(input bit keep);
    if (keep) begin
      bus.inst_src1 = 3'($urandom);
      bus.inst_src2 = 3'($urandom);
      bus.inst_tag  = 8'($urandom);
    end else bus.inst_valid = 1'b0;
  endtask
  task automatic fetch(input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] tg, input int nrdy,
                       input bit keep, input logic [19:0] w_iss, input logic [19:0] w_cap,
                       input logic [19:0] w_val, input bit ce, input logic [15:0] ea, input logic [15:0] eb);
    cur1 = s1;
    cur2 = s2;
    bus.inst_valid = 1'b1;
    bus.inst_src1  = s1;
    bus.inst_src2  = s2;
    bus.inst_tag   = tg;
    chk("idle_inst_ready", 32'(bus.inst_ready), 32'd1);
    wr(20'd0);
    step();
    busy_inputs(keep);
    chk("issue_inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("issue_op_valid", 32'(bus.op_valid), 32'd0);
    chk("issue_readReg1", 32'(bus.readReg1), 32'(s1));
    chk("issue_readReg2", 32'(bus.readReg2), 32'(s2));
    wr(w_iss);
    step();
    busy_inputs(keep);
    chk("capture_op_valid", 32'(bus.op_valid), 32'd0);
    chk("capture_readReg1", 32'(bus.readReg1), 32'(s1));
    chk("capture_inst_ready", 32'(bus.inst_ready), 32'd0);
    wr(w_cap);
    step();
    busy_inputs(keep);
    chk("valid_entry_op_valid", 32'(bus.op_valid), 32'd1);
    chk("valid_entry_opA", 32'(bus.opA), 32'(rf[s1]));
    chk("valid_entry_opB", 32'(bus.opB), 32'(rf[s2]));
    chk("valid_entry_op_tag", 32'(bus.op_tag), 32'(tg));
    if (ce) begin
      chk("valid_entry_opA_const", 32'(bus.opA), 32'(ea));
      chk("valid_entry_opB_const", 32'(bus.opB), 32'(eb));
    end
    for (int i = 0; i < nrdy; i++) begin
      wr(i == 0 ? w_val : 20'd0);
      step();
      busy_inputs(keep);
      chk("held_op_valid", 32'(bus.op_valid), 32'd1);
      chk("held_inst_ready", 32'(bus.inst_ready), 32'd0);
      chk("held_opA", 32'(bus.opA), 32'(rf[s1]));
      chk("held_opB", 32'(bus.opB), 32'(rf[s2]));
      chk("held_op_tag", 32'(bus.op_tag), 32'(tg));
    end
    bus.op_ready = 1'b1;
    wr(20'd0);
    step();
    bus.op_ready = 1'b0;
    busy_inputs(keep);
    chk("done_op_valid", 32'(bus.op_valid), 32'd0);
    chk("done_inst_ready", 32'(bus.inst_ready), 32'd1);
  endtask
  initial begin
    bus.inst_valid = 1'b0;
    bus.inst_src1 = '0;
    bus.inst_src2 = '0;
    bus.inst_tag = '0;
    bus.op_ready = 1'b0;
    {bus.regWrite, bus.writeReg, bus.writeFile} = 20'd0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_inst_ready", 32'(bus.inst_ready), 32'd1);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_opA", 32'(bus.opA), 32'd0);
    chk("rst_opB", 32'(bus.opB), 32'd0);
    chk("rst_op_tag", 32'(bus.op_tag), 32'd0);
    chk("rst_readReg1", 32'(bus.readReg1), 32'd0);
    chk("rst_readReg2", 32'(bus.readReg2), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    fetch(3'd2, 3'd5, 8'h11, 0, 1'b0, 20'd0, 20'd0, 20'd0, 1'b1, 16'd256, 16'd0);
    fetch(3'd1, 3'd2, 8'h22, 1, 1'b0, wv(1, 3'd7, 16'h1111), wv(1, 3'd7, 16'h2222), 20'd0, 1'b1, 16'd0, 16'd256);
    fetch(3'd3, 3'd3, 8'h33, 0, 1'b0, wv(1, 3'd3, 16'h1234), 20'd0, 20'd0, 1'b1, 16'h1234, 16'h1234);
    fetch(3'd4, 3'd0, 8'h44, 5, 1'b0, 20'd0, wv(1, 3'd4, 16'hBEEF), wv(1, 3'd4, 16'hCAFE), 1'b1, 16'hBEEF, 16'd0);
    chk("snoop_opA_cafe_in_rf", 32'(rf[4]), 32'h0000CAFE);
    fetch(3'd6, 3'd7, 8'hA5, 10, 1'b1, 20'd0, 20'd0, 20'd0, 1'b0, 16'd0, 16'd0);
    fetch(3'd2, 3'd4, 8'h3C, 2, 1'b0, 20'd0, 20'd0, 20'd0, 1'b1, 16'd256, 16'hCAFE);
    cur1 = 3'd6;
    cur2 = 3'd1;
    bus.inst_valid = 1'b1;
    bus.inst_src1 = 3'd6;
    bus.inst_src2 = 3'd1;
    bus.inst_tag = 8'h77;
    step();
    bus.inst_valid = 1'b0;
    wr(wv(1, 3'd6, 16'h5555));
    step();
    wr(20'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_inst_ready", 32'(bus.inst_ready), 32'd1);
    chk("abort_op_valid", 32'(bus.op_valid), 32'd0);
    chk("abort_opA", 32'(bus.opA), 32'd0);
    chk("abort_opB", 32'(bus.opB), 32'd0);
    chk("abort_readReg1", 32'(bus.readReg1), 32'd0);
    chk("abort_readReg2", 32'(bus.readReg2), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle_op_valid", 32'(bus.op_valid), 32'd0);
    fetch(3'd6, 3'd1, 8'h78, 1, 1'b0, 20'd0, 20'd0, 20'd0, 1'b1, 16'h5555, 16'd0);
    rnd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] a, b;
      a = 3'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 3'($urandom);
      fetch(a, b, 8'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 20'd0, 20'd0, 20'd0, 1'b0, 16'd0, 16'd0);
    end
    rnd = 1'b0;
    bus.inst_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
